pipeline_stage_regs: RTL and testbench

- Holds the four inter-stage latches of the ERV25 5-stage pipeline (F→D, D→R, R→E, E→W) and the fetch PC register.
- Consumes the per-latch enable/flush controls produced by the hazard/control unit.
- Returns the per-stage rd/reg_flag/valid state that the hazard unit inspects.
- Also keeps stall, flush and retire performance counters and a sticky protocol-error flag for control-sequence violations.

---
 rtl/pipe_pkg.sv | 39 +++
 rtl/pipeline_stage_regs_latch.sv | 34 +++
 rtl/pipeline_stage_regs.sv | 161 ++++++++++++++++
 tb/tb_pipeline_stage_regs.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and reference latch-record layouts for the ERV25 pipeline registers.
package pipe_pkg;

  localparam int unsigned          RD_W             = 5;
  localparam int unsigned          PC_STEP          = 4;
  localparam int unsigned          PKG_XLEN         = 32;
  localparam int unsigned          PKG_CTRL_W       = 16;
  localparam logic [PKG_XLEN-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;

  // Default-width (XLEN=32, CTRL_W=16) record layouts; the top re-declares them per parameter set.
  typedef struct packed {
    logic                  valid;
    logic [PKG_XLEN-1:0]   instr;
    logic [PKG_XLEN-1:0]   pc;
  } stage_d_t;

  typedef struct packed {
    logic                  valid;
    logic [RD_W-1:0]       rd;
    logic                  flag;
    logic [PKG_CTRL_W-1:0] ctrl;
    logic [PKG_XLEN-1:0]   pc;
  } stage_r_t;

  typedef stage_r_t stage_e_t;

  typedef struct packed {
    logic                  valid;
    logic [RD_W-1:0]       rd;
    logic                  flag;
    logic [PKG_XLEN-1:0]   result;
  } stage_w_t;

  localparam stage_d_t BUBBLE_D = '0;
  localparam stage_r_t BUBBLE_R = '0;
  localparam stage_e_t BUBBLE_E = '0;
  localparam stage_w_t BUBBLE_W = '0;

endpackage

// File: rtl/pipeline_stage_regs_latch.sv
// One inter-stage latch: flush inserts an all-zero bubble, else enable loads, else hold.
module pipe_latch #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         flush_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (flush_i) begin
      q_d = '0;
    end else if (en_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipeline_stage_regs.sv
// ERV25 inter-stage latches, fetch PC, saturating perf counters and sticky protocol-error flag.
module pipeline_stage_regs
  import pipe_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     CTRL_W   = 16,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int unsigned     CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_F_D,
  input  logic              enable_D_R,
  input  logic              enable_R_E,
  input  logic              enable_E_W,
  input  logic              flush_F_D,
  input  logic              flush_D_R,
  input  logic              flush_R_E,
  input  logic              flush_E_W,
  input  logic [XLEN-1:0]   instr_F,
  input  logic              branch_E,
  input  logic [XLEN-1:0]   branch_target_E,
  input  logic [4:0]        rd_D,
  input  logic              reg_flag_D,
  input  logic [CTRL_W-1:0] ctrl_D,
  input  logic [XLEN-1:0]   result_E,
  output logic [XLEN-1:0]   pc_F,
  output logic [XLEN-1:0]   instr_D,
  output logic [XLEN-1:0]   pc_D,
  output logic              valid_D,
  output logic [4:0]        rd_R,
  output logic              reg_flag_R,
  output logic [CTRL_W-1:0] ctrl_R,
  output logic [XLEN-1:0]   pc_R,
  output logic              valid_R,
  output logic [4:0]        rd_E,
  output logic              reg_flag_E,
  output logic [CTRL_W-1:0] ctrl_E,
  output logic [XLEN-1:0]   pc_E,
  output logic              valid_E,
  output logic [4:0]        rd_W,
  output logic              reg_flag_W,
  output logic [XLEN-1:0]   result_W,
  output logic              valid_W,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic              protocol_err
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } d_rec_t;

  typedef struct packed {
    logic              valid;
    logic [RD_W-1:0]   rd;
    logic              flag;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   pc;
  } re_rec_t;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            flag;
    logic [XLEN-1:0] result;
  } w_rec_t;

  d_rec_t  d_in, d_q;
  re_rec_t r_in, r_q, e_in, e_q;
  w_rec_t  w_in, w_q;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d, retire_q, retire_d;
  logic             err_q, err_d;

  assign d_in = '{valid: 1'b1, instr: instr_F, pc: pc_q};
  assign r_in = '{valid: d_q.valid, rd: rd_D, flag: reg_flag_D, ctrl: ctrl_D, pc: d_q.pc};
  assign e_in = r_q;
  assign w_in = '{valid: e_q.valid, rd: e_q.rd, flag: e_q.flag, result: result_E};

  pipe_latch #(.W($bits(d_rec_t))) u_lat_fd (
    .clk_i(clk), .rst_ni(rst_n), .en_i(enable_F_D), .flush_i(flush_F_D), .d_i(d_in), .q_o(d_q)
  );
  pipe_latch #(.W($bits(re_rec_t))) u_lat_dr (
    .clk_i(clk), .rst_ni(rst_n), .en_i(enable_D_R), .flush_i(flush_D_R), .d_i(r_in), .q_o(r_q)
  );
  pipe_latch #(.W($bits(re_rec_t))) u_lat_re (
    .clk_i(clk), .rst_ni(rst_n), .en_i(enable_R_E), .flush_i(flush_R_E), .d_i(e_in), .q_o(e_q)
  );
  pipe_latch #(.W($bits(w_rec_t))) u_lat_ew (
    .clk_i(clk), .rst_ni(rst_n), .en_i(enable_E_W), .flush_i(flush_E_W), .d_i(w_in), .q_o(w_q)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    sat_inc = (inc && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  always_comb begin
    pc_d = pc_q;
    if (branch_E && e_q.valid) begin
      pc_d = branch_target_E;
    end else if (enable_F_D) begin
      pc_d = pc_q + XLEN'(PC_STEP);
    end
  end

  always_comb begin
    stall_d  = sat_inc(stall_q,  !enable_F_D && !flush_F_D);
    flush_d  = sat_inc(flush_q,  flush_F_D);
    retire_d = sat_inc(retire_q, enable_E_W && !flush_E_W && e_q.valid);
    // A valid stage would be copied forward while its own latch also holds it.
    err_d = err_q
          | (!enable_F_D && enable_D_R && !flush_D_R && d_q.valid)
          | (!enable_D_R && enable_R_E && !flush_R_E && r_q.valid)
          | (!enable_R_E && enable_E_W && !flush_E_W && e_q.valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      stall_q  <= '0;
      flush_q  <= '0;
      retire_q <= '0;
      err_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
      retire_q <= retire_d;
      err_q    <= err_d;
    end
  end

  assign pc_F         = pc_q;
  assign instr_D      = d_q.instr;
  assign pc_D         = d_q.pc;
  assign valid_D      = d_q.valid;
  assign rd_R         = r_q.rd;
  assign reg_flag_R   = r_q.flag & r_q.valid;
  assign ctrl_R       = r_q.ctrl;
  assign pc_R         = r_q.pc;
  assign valid_R      = r_q.valid;
  assign rd_E         = e_q.rd;
  assign reg_flag_E   = e_q.flag & e_q.valid;
  assign ctrl_E       = e_q.ctrl;
  assign pc_E         = e_q.pc;
  assign valid_E      = e_q.valid;
  assign rd_W         = w_q.rd;
  assign reg_flag_W   = w_q.flag & w_q.valid;
  assign result_W     = w_q.result;
  assign valid_W      = w_q.valid;
  assign stall_cnt    = stall_q;
  assign flush_cnt    = flush_q;
  assign retire_cnt   = retire_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_pipeline_stage_regs.sv
// Directed bench for pipeline_stage_regs with a retire-side scoreboard during free run.
module tb_pipeline_stage_regs;

  localparam logic [31:0] MASK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable_F_D, enable_D_R, enable_R_E, enable_E_W;
  logic        flush_F_D, flush_D_R, flush_R_E, flush_E_W;
  logic [31:0] instr_F, branch_target_E, result_E;
  logic        branch_E;
  logic [4:0]  rd_D;
  logic        reg_flag_D;
  logic [15:0] ctrl_D;
  logic [31:0] pc_F, instr_D, pc_D, pc_R, pc_E, result_W;
  logic        valid_D, valid_R, valid_E, valid_W;
  logic [4:0]  rd_R, rd_E, rd_W;
  logic        reg_flag_R, reg_flag_E, reg_flag_W;
  logic [15:0] ctrl_R, ctrl_E;
  logic [3:0]  stall_cnt, flush_cnt, retire_cnt;
  logic        protocol_err;

  pipeline_stage_regs #(.XLEN(32), .CTRL_W(16), .RESET_PC(32'h0), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .enable_F_D(enable_F_D), .enable_D_R(enable_D_R), .enable_R_E(enable_R_E), .enable_E_W(enable_E_W),
    .flush_F_D(flush_F_D), .flush_D_R(flush_D_R), .flush_R_E(flush_R_E), .flush_E_W(flush_E_W),
    .instr_F(instr_F), .branch_E(branch_E), .branch_target_E(branch_target_E),
    .rd_D(rd_D), .reg_flag_D(reg_flag_D), .ctrl_D(ctrl_D), .result_E(result_E),
    .pc_F(pc_F), .instr_D(instr_D), .pc_D(pc_D), .valid_D(valid_D),
    .rd_R(rd_R), .reg_flag_R(reg_flag_R), .ctrl_R(ctrl_R), .pc_R(pc_R), .valid_R(valid_R),
    .rd_E(rd_E), .reg_flag_E(reg_flag_E), .ctrl_E(ctrl_E), .pc_E(pc_E), .valid_E(valid_E),
    .rd_W(rd_W), .reg_flag_W(reg_flag_W), .result_W(result_W), .valid_W(valid_W),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // Instruction memory, decoder and EX models driving the design's upstream inputs.
  logic [31:0] rom [8] = '{32'h0050_0093, 32'h0000_0013, 32'h00a1_0113, 32'h00c2_8293,
                           32'h4020_8033, 32'h00f0_0f93, 32'h0010_0313, 32'h0020_8463};
  assign instr_F    = rom[pc_F[4:2]];
  assign rd_D       = instr_D[11:7];
  assign reg_flag_D = (instr_D[11:7] != 5'd0);
  assign ctrl_D     = instr_D[15:0];
  assign result_E   = pc_E ^ MASK;

  typedef struct {
    logic [4:0]  rd;
    logic        flag;
    logic [31:0] res;
  } exp_t;

  exp_t        sb[$];
  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctl(input logic [3:0] en, input logic [3:0] fl);
    {enable_F_D, enable_D_R, enable_R_E, enable_E_W} = en;
    {flush_F_D, flush_D_R, flush_R_E, flush_E_W}     = fl;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] w;
    exp_t        e;

    rst_n = 1'b0;
    branch_E = 1'b0;
    branch_target_E = '0;
    set_ctl(4'b1111, 4'b0000);
    #2;
    chk("rst_pc_F", pc_F, 32'h0);
    chk("rst_valids", {valid_D, valid_R, valid_E, valid_W}, 4'b0000);
    chk("rst_cnts", {stall_cnt, flush_cnt, retire_cnt}, 12'h000);
    chk("rst_perr", protocol_err, 1'b0);
    #10;
    rst_n = 1'b1;

    // Free run with scoreboard: each fetch predicts the W-stage record four edges later.
    exp_pc = 32'h0;
    for (int i = 0; i < 8; i++) begin
      chk("fr_pc_F", pc_F, exp_pc);
      w = rom[exp_pc[4:2]];
      sb.push_back('{rd: w[11:7], flag: (w[11:7] != 5'd0), res: exp_pc ^ MASK});
      tick();
      exp_pc += 32'd4;
      chk("fr_valid_W", valid_W, (i >= 3));
      if (i >= 3) begin
        chk("fr_sb_nonempty", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("fr_rd_W", rd_W, e.rd);
          chk("fr_flag_W", reg_flag_W, e.flag);
          chk("fr_result_W", result_W, e.res);
        end
      end
      if (i == 3) chk("fr_retire1", retire_cnt, 4'd1);
    end

    // Asynchronous reset mid-run.
    chk("mr_pre_valid_E", valid_E, 1'b1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mr_valids", {valid_D, valid_R, valid_E, valid_W}, 4'b0000);
    chk("mr_pc_F", pc_F, 32'h0);
    chk("mr_cnts", {stall_cnt, flush_cnt, retire_cnt}, 12'h000);
    #1;
    rst_n = 1'b1;
    tick();
    chk("mr_pc_4", pc_F, 32'h4);
    tick();
    chk("mr_pc_8", pc_F, 32'h8);

    // Stall front, bubble into E.
    set_ctl(4'b0011, 4'b0010);
    tick();
    w = rom[0];
    chk("st_pc_F", pc_F, 32'h8);
    chk("st_instr_D", instr_D, rom[1]);
    chk("st_rd_R", rd_R, w[11:7]);
    chk("st_valid_E", valid_E, 1'b0);
    chk("st_flag_E", reg_flag_E, 1'b0);
    chk("st_stall_cnt", stall_cnt, 4'd1);
    chk("st_perr", protocol_err, 1'b0);

    // Taken branch with front flush.
    set_ctl(4'b1111, 4'b0000);
    tick();
    chk("br_pre_valid_E", valid_E, 1'b1);
    branch_E = 1'b1;
    branch_target_E = 32'h40;
    set_ctl(4'b1111, 4'b1100);
    tick();
    chk("br_pc_F", pc_F, 32'h40);
    chk("br_valid_DR", {valid_D, valid_R}, 2'b00);
    chk("br_flush_cnt", flush_cnt, 4'd1);
    branch_E = 1'b0;
    set_ctl(4'b1111, 4'b0000);
    tick();
    tick();
    chk("fp_pre_valid_R", valid_R, 1'b1);

    // Flush beats a deasserted enable.
    set_ctl(4'b1000, 4'b0100);
    tick();
    chk("fp_valid_R", valid_R, 1'b0);
    chk("fp_perr0", protocol_err, 1'b0);
    set_ctl(4'b1111, 4'b0000);
    tick();
    chk("pe_pre_valid_R", valid_R, 1'b1);

    // Duplication: R->E loads while D->R holds a valid instruction.
    set_ctl(4'b1011, 4'b0000);
    tick();
    chk("pe_set", protocol_err, 1'b1);
    set_ctl(4'b1111, 4'b0000);
    tick();
    tick();
    chk("pe_sticky", protocol_err, 1'b1);
    chk("pe_pc_F", pc_F, 32'h5C);

    // Counter saturation with the whole pipe frozen.
    set_ctl(4'b0000, 4'b0000);
    for (int i = 0; i < 13; i++) tick();
    chk("sat_14", stall_cnt, 4'd14);
    for (int i = 0; i < 7; i++) tick();
    chk("sat_15", stall_cnt, 4'd15);
    chk("sat_pc_hold", pc_F, 32'h5C);
    chk("wr_pre_valid_E", valid_E, 1'b1);

    // Redirect ignores enable_F_D; increment wraps modulo 2^32.
    branch_E = 1'b1;
    branch_target_E = 32'hFFFF_FFFC;
    tick();
    chk("wr_pc_top", pc_F, 32'hFFFF_FFFC);
    branch_E = 1'b0;
    set_ctl(4'b1000, 4'b0000);
    tick();
    chk("wr_pc_wrap", pc_F, 32'h0);
    chk("wr_stall_sat", stall_cnt, 4'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
